// File: rtl/hex_display_driver_if.sv
// Bundles the value/strobe inputs and the multiplexed display outputs of hex_display_driver.
// master drives value, load, dp and blank requests; slave (the driver) drives the display lines.
interface hex_display_driver_if;
   logic [15:0] disp_val;
   logic        load;
   logic [3:0]  dp_in;
   logic        blank;
   logic [7:0]  hex_seg;
   logic [3:0]  hex_grid;
   logic        frame_tick;

   modport master (
      output disp_val,
      output load,
      output dp_in,
      output blank,
      input  hex_seg,
      input  hex_grid,
      input  frame_tick
   );

   modport slave (
      input  disp_val,
      input  load,
      input  dp_in,
      input  blank,
      output hex_seg,
      output hex_grid,
      output frame_tick
   );
endinterface

// File: rtl/hex_display_driver.sv
// Four-digit multiplexed hex display driver with frame-synchronous value commit.
// Optional HEX_LEADING_ZERO_BLANK_EN: dark segments on leading-zero digits 3..1.
module hex_display_driver #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic               Clk,
   input  logic               Reset,
   hex_display_driver_if.slave disp
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   // scan state
   logic [CNT_W-1:0] refresh_cnt_reg, refresh_cnt_next;
   logic [1:0]       digit_idx_reg, digit_idx_next;
   logic             tick;
   logic             frame_boundary;

   // value path
   logic [15:0]      shadow_reg, shadow_next;
   logic [15:0]      active_reg, active_next;
   logic             pending_reg, pending_next;

   // registered outputs
   logic [7:0]       hex_seg_reg, hex_seg_next;
   logic [3:0]       hex_grid_reg, hex_grid_next;
   logic             frame_tick_reg;

   logic [3:0]       digit_nib [4];
   logic [3:0]       lz_suppress;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] segs;
      case (nib)
         4'h0:    segs = 7'h40;
         4'h1:    segs = 7'h79;
         4'h2:    segs = 7'h24;
         4'h3:    segs = 7'h30;
         4'h4:    segs = 7'h19;
         4'h5:    segs = 7'h12;
         4'h6:    segs = 7'h02;
         4'h7:    segs = 7'h78;
         4'h8:    segs = 7'h00;
         4'h9:    segs = 7'h10;
         4'hA:    segs = 7'h08;
         4'hB:    segs = 7'h03;
         4'hC:    segs = 7'h46;
         4'hD:    segs = 7'h21;
         4'hE:    segs = 7'h06;
         default: segs = 7'h0E;
      endcase
      return segs;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_nib
         assign digit_nib[gi] = active_reg[4*gi +: 4];
      end
   endgenerate

`ifdef HEX_LEADING_ZERO_BLANK_EN
   // A digit is a leading zero when it and every higher nibble are zero; digit 0 always shows.
   assign lz_suppress[0] = 1'b0;
   generate
      for (gi = 1; gi < 4; gi++) begin : g_lz
         assign lz_suppress[gi] = ~|active_reg[15:4*gi];
      end
   endgenerate
`else
   assign lz_suppress = 4'b0000;
`endif

   assign tick           = (refresh_cnt_reg == CNT_MAX);
   assign frame_boundary = tick && (digit_idx_reg == 2'd3);

   // ---------------- scan: state register ----------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         refresh_cnt_reg <= '0;
         digit_idx_reg   <= 2'd0;
      end else begin
         refresh_cnt_reg <= refresh_cnt_next;
         digit_idx_reg   <= digit_idx_next;
      end
   end

   // ---------------- scan: next state ----------------
   always_comb begin
      refresh_cnt_next = refresh_cnt_reg + 1'b1;
      digit_idx_next   = digit_idx_reg;
      if (tick) begin
         refresh_cnt_next = '0;
         digit_idx_next   = digit_idx_reg + 2'd1;
      end
   end

   // ---------------- scan: output decode ----------------
   always_comb begin
      hex_grid_next = 4'hF;
      hex_seg_next  = 8'hFF;
      if (!disp.blank) begin
         hex_grid_next = ~(4'b0001 << digit_idx_reg);
         hex_seg_next  = {~disp.dp_in[digit_idx_reg],
                          lz_suppress[digit_idx_reg] ? 7'h7F
                                                     : seg_decode(digit_nib[digit_idx_reg])};
      end
   end

   // A load landing on the boundary bypasses the shadow so it is not lost or delayed a frame.
   always_comb begin
      shadow_next  = shadow_reg;
      active_next  = active_reg;
      pending_next = pending_reg;
      if (disp.load) begin
         shadow_next = disp.disp_val;
      end
      if (frame_boundary) begin
         if (disp.load) begin
            active_next = disp.disp_val;
         end else if (pending_reg) begin
            active_next = shadow_reg;
         end
         pending_next = 1'b0;
      end else if (disp.load) begin
         pending_next = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         shadow_reg  <= 16'h0000;
         active_reg  <= 16'h0000;
         pending_reg <= 1'b0;
      end else begin
         shadow_reg  <= shadow_next;
         active_reg  <= active_next;
         pending_reg <= pending_next;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         hex_seg_reg    <= 8'hFF;
         hex_grid_reg   <= 4'hF;
         frame_tick_reg <= 1'b0;
      end else begin
         hex_seg_reg    <= hex_seg_next;
         hex_grid_reg   <= hex_grid_next;
         frame_tick_reg <= frame_boundary;
      end
   end

   assign disp.hex_seg    = hex_seg_reg;
   assign disp.hex_grid   = hex_grid_reg;
   assign disp.frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_hex_display_driver.sv
// Randomized and directed bench for hex_display_driver against a frame-level reference model.
// The model tracks elapsed cycles since reset and the value each frame should display.
module tb_hex_display_driver;

   localparam int DIV   = 4;
   localparam int FRAME = 4 * DIV;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   hex_display_driver_if disp ();

   hex_display_driver #(.REFRESH_DIV(DIV)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .disp  (disp)
   );

   int checks = 0;
   int errors = 0;

   // reference model: cycles since reset release, value shown this frame, value for next frame
   int          k;
   logic [15:0] cur_val;
   logic [15:0] nxt_val;
   logic [7:0]  seg_tab [16];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h at t=%0t k=%0d", tag, obs, exp, $time, k);
      end
   endtask

   task automatic step(input logic rst, input logic ld, input logic [15:0] val,
                       input logic [3:0] dp, input logic bl);
      logic [7:0] e_seg;
      logic [3:0] e_grid;
      logic       e_ft;
      int         idx;
      logic [3:0] nib;
      logic       bnd;
      @(negedge Clk);
      Reset         = rst;
      disp.load     = ld;
      disp.disp_val = val;
      disp.dp_in    = dp;
      disp.blank    = bl;
      if (rst) begin
         e_seg   = 8'hFF;
         e_grid  = 4'hF;
         e_ft    = 1'b0;
         k       = 0;
         cur_val = 16'h0000;
         nxt_val = 16'h0000;
      end else begin
         idx  = (k / DIV) % 4;
         bnd  = (k % FRAME) == FRAME - 1;
         nib  = 4'((cur_val >> (4 * idx)) & 16'hF);
         e_ft = bnd;
         if (bl) begin
            e_seg  = 8'hFF;
            e_grid = 4'hF;
         end else begin
            e_grid = 4'hF ^ 4'(1 << idx);
            e_seg  = seg_tab[nib];
            e_seg[7] = ~dp[idx];
`ifdef HEX_LEADING_ZERO_BLANK_EN
            if (idx > 0 && (cur_val >> (4 * idx)) == 16'h0000) e_seg[6:0] = 7'h7F;
`endif
         end
         if (ld) begin
            $display("load %h at frame cycle %0d%s", val, k % FRAME, bnd ? " (boundary)" : "");
            nxt_val = val;
         end
         if (bnd) cur_val = nxt_val;
         k++;
      end
      @(posedge Clk);
      #1;
      check("hex_grid", {12'h000, disp.hex_grid}, {12'h000, e_grid});
      check("hex_seg", {8'h00, disp.hex_seg}, {8'h00, e_seg});
      check("frame_tick", {15'h0000, disp.frame_tick}, {15'h0000, e_ft});
   endtask

   task automatic idle(input int n, input logic [3:0] dp);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, dp, 1'b0);
   endtask

   // advance until the next edge will occur at the given position within a frame
   task automatic goto_pos(input int pos);
      for (int i = 0; i < FRAME && (k % FRAME) != pos; i++) idle(1, 4'h0);
   endtask

   initial begin
      seg_tab[0]  = 8'hC0; seg_tab[1]  = 8'hF9; seg_tab[2]  = 8'hA4; seg_tab[3]  = 8'hB0;
      seg_tab[4]  = 8'h99; seg_tab[5]  = 8'h92; seg_tab[6]  = 8'h82; seg_tab[7]  = 8'hF8;
      seg_tab[8]  = 8'h80; seg_tab[9]  = 8'h90; seg_tab[10] = 8'h88; seg_tab[11] = 8'h83;
      seg_tab[12] = 8'hC6; seg_tab[13] = 8'hA1; seg_tab[14] = 8'h86; seg_tab[15] = 8'h8E;
      k = 0; cur_val = 16'h0000; nxt_val = 16'h0000;
      Reset = 1'b1;
      disp.load = 1'b0; disp.disp_val = 16'h0000; disp.dp_in = 4'h0; disp.blank = 1'b0;

      // reset and idle scan of zero
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
      idle(2 * FRAME, 4'h0);

      // load mid-frame at digit 1
      goto_pos(DIV);
      step(1'b0, 1'b1, 16'h0405, 4'h0, 1'b0);
      idle(2 * FRAME, 4'h0);

      // two loads in one frame: last wins
      goto_pos(2);
      step(1'b0, 1'b1, 16'h1234, 4'h0, 1'b0);
      idle(3, 4'h0);
      step(1'b0, 1'b1, 16'hABCD, 4'h0, 1'b0);
      idle(2 * FRAME, 4'h0);

      // load on the exact boundary cycle, then a boundary with no load
      goto_pos(FRAME - 1);
      step(1'b0, 1'b1, 16'h00F0, 4'h0, 1'b0);
      idle(2 * FRAME, 4'h0);

      // decimal point, blank at digit 2, reset mid-frame
      idle(FRAME, 4'b1000);
      goto_pos(2 * DIV);
      for (int i = 0; i < FRAME + 3; i++) step(1'b0, 1'b0, 16'h0000, 4'b1000, 1'b1);
      idle(3, 4'b1000);
      step(1'b1, 1'b0, 16'h0000, 4'b1000, 1'b0);
      step(1'b1, 1'b0, 16'h0000, 4'b1000, 1'b0);
      idle(FRAME, 4'b1000);

      // leading-zero candidates
      step(1'b0, 1'b1, 16'h0014, 4'h0, 1'b0);
      idle(2 * FRAME, 4'h0);
      step(1'b0, 1'b1, 16'h0000, 4'h0, 1'b0);
      idle(2 * FRAME, 4'h0);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic        r_rst, r_ld, r_bl;
         logic [15:0] r_val;
         r_rst = ($urandom_range(0, 299) == 0);
         r_ld  = ($urandom_range(0, 11) == 0);
         r_bl  = ($urandom_range(0, 7) == 0);
         r_val = 16'($urandom) >> $urandom_range(0, 12);
         step(r_rst, r_ld, r_val, 4'($urandom), r_bl);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
